// File: rtl/perf_counter_multi_if.sv
// Purpose: bundles the PC tap, control, overlay pixel feed and result buses of perf_counter_multi.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running level/pulse signals.
// Ports (modports):
//   master - drives pc, pc_valid, clear, start_pc, stop_pc, pixel_x, pixel_y; observes results
//   slave  - the counter block; observes the inputs above, drives cycles, time_bcd, running,
//            done, saturated, digit_request, digit
interface perf_counter_multi_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int CYCLE_WIDTH  = 32,
  parameter int TIME_DIGITS  = 4
);
  logic [15:0]                           pc;
  logic                                  pc_valid;
  logic                                  clear;
  logic [16*NUM_CHANNELS-1:0]            start_pc;
  logic [16*NUM_CHANNELS-1:0]            stop_pc;
  logic [9:0]                            pixel_x;
  logic [9:0]                            pixel_y;
  logic [CYCLE_WIDTH*NUM_CHANNELS-1:0]   cycles;
  logic [4*TIME_DIGITS*NUM_CHANNELS-1:0] time_bcd;
  logic [NUM_CHANNELS-1:0]               running;
  logic [NUM_CHANNELS-1:0]               done;
  logic [NUM_CHANNELS-1:0]               saturated;
  logic                                  digit_request;
  logic [3:0]                            digit;

  modport master (
    output pc, pc_valid, clear, start_pc, stop_pc, pixel_x, pixel_y,
    input  cycles, time_bcd, running, done, saturated, digit_request, digit
  );

  modport slave (
    input  pc, pc_valid, clear, start_pc, stop_pc, pixel_x, pixel_y,
    output cycles, time_bcd, running, done, saturated, digit_request, digit
  );
endinterface

// File: rtl/perf_counter_multi.sv
// Purpose: per-channel start/stop PC window timer (saturating hex cycles + BCD hundredths) with VGA digit feed.
// Latency: counts update on the edge after a RUNNING cycle; digit_request/digit lag pixel_x/pixel_y by 1 cycle.
// Backpressure: none; passively taps the retiring PC and the pixel scan.
// Ports:
//   CLK_50 - system clock
//   reset  - synchronous active-high reset
//   bus    - perf_counter_multi_if.slave (PC tap, clear, start/stop addresses, pixel position in;
//            cycles, time_bcd, running, done, saturated, digit_request, digit out)
module perf_counter_multi #(
  parameter int NUM_CHANNELS     = 2,
  parameter int CYCLE_WIDTH      = 32,
  parameter int TIME_DIGITS      = 4,
  parameter int CLKS_PER_TICK    = 500000,
  parameter int HEX_DIGIT_WIDTH  = 16,
  parameter int HEX_DIGIT_HEIGHT = 32,
  parameter int TOP_Y            = 384
) (
  input  logic                CLK_50,
  input  logic                reset,
  perf_counter_multi_if.slave bus
);

  localparam int CYC_DIGITS = CYCLE_WIDTH / 4;
  localparam int TIME_W     = 4 * TIME_DIGITS;
  localparam int PRESC_W    = $clog2(CLKS_PER_TICK);

  localparam logic [CYCLE_WIDTH-1:0] CYC_MAX   = '1;
  localparam logic [CYCLE_WIDTH-1:0] CYC_NEAR  = CYC_MAX - 1'b1;
  localparam logic [TIME_W-1:0]      ALL9      = {TIME_DIGITS{4'h9}};
  localparam logic [PRESC_W-1:0]     TICK_LAST = PRESC_W'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               r_state     [NUM_CHANNELS];
  state_t               w_state_nxt [NUM_CHANNELS];
  logic [CYCLE_WIDTH-1:0] r_cycles  [NUM_CHANNELS];
  logic [TIME_W-1:0]      r_time    [NUM_CHANNELS];
  logic [TIME_W-1:0]      w_time_inc[NUM_CHANNELS];
  logic [PRESC_W-1:0]     r_presc   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_sat;

  logic        r_digit_req;
  logic [3:0]  r_digit;
  logic        w_digit_req;
  logic [3:0]  w_digit;
  logic [31:0] w_px;
  logic [31:0] w_py;
  logic [31:0] w_idx;

  // Ripple BCD increment, least significant digit first; a digit only rolls 9->0 when carried into.
  function automatic logic [TIME_W-1:0] bcd_inc(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] res;
    logic              carry;
    res   = v;
    carry = 1'b1;
    for (int d = 0; d < TIME_DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          res[4*d +: 4] = 4'd0;
        end else begin
          res[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // ---------------- channel FSMs ----------------
  always_ff @(posedge CLK_50) begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (reset || bus.clear) begin
        r_state[k] <= ST_IDLE;
      end else begin
        r_state[k] <= w_state_nxt[k];
      end
    end
  end

  // Start is only looked at in IDLE and stop only in RUNNING, so start==stop takes two matches.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_state_nxt[k] = r_state[k];
      case (r_state[k])
        ST_IDLE: begin
          if (bus.pc_valid && (bus.pc == bus.start_pc[16*k +: 16])) begin
            w_state_nxt[k] = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (bus.pc_valid && (bus.pc == bus.stop_pc[16*k +: 16])) begin
            w_state_nxt[k] = ST_DONE;
          end
        end
        default: begin
          w_state_nxt[k] = r_state[k];
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_time_inc[k] = bcd_inc(r_time[k]);
    end
  end

  // ---------------- counters ----------------
  // Counting keys off the registered state: the start-detect edge sees IDLE (not counted),
  // the stop-detect edge still sees RUNNING (counted). The prescaler simply stops in DONE.
  always_ff @(posedge CLK_50) begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (reset || bus.clear) begin
        r_cycles[k] <= '0;
        r_time[k]   <= '0;
        r_presc[k]  <= '0;
        r_sat[k]    <= 1'b0;
      end else if (r_state[k] == ST_RUNNING) begin
        if (r_cycles[k] != CYC_MAX) begin
          r_cycles[k] <= r_cycles[k] + 1'b1;
          if (r_cycles[k] == CYC_NEAR) begin
            r_sat[k] <= 1'b1;
          end
        end
        if (r_presc[k] == TICK_LAST) begin
          r_presc[k] <= '0;
          if (r_time[k] != ALL9) begin
            r_time[k] <= w_time_inc[k];
            if (w_time_inc[k] == ALL9) begin
              r_sat[k] <= 1'b1;
            end
          end
        end else begin
          r_presc[k] <= r_presc[k] + 1'b1;
        end
      end
    end
  end

  // ---------------- overlay ----------------
  assign w_px  = {22'd0, bus.pixel_x};
  assign w_py  = {22'd0, bus.pixel_y};
  assign w_idx = w_px / 32'(HEX_DIGIT_WIDTH);

  // Channel k owns two stacked lines: cycles (hex) then time (BCD); leftmost cell is the MS digit.
  always_comb begin
    logic [31:0] v_base;
    w_digit_req = 1'b0;
    w_digit     = 4'd0;
    v_base      = 32'd0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      v_base = 32'(TOP_Y) + 32'(2 * k * HEX_DIGIT_HEIGHT);
      if ((w_py >= v_base) && (w_py < v_base + 32'(HEX_DIGIT_HEIGHT)) &&
          (w_idx < 32'(CYC_DIGITS))) begin
        w_digit_req = 1'b1;
        w_digit     = 4'(r_cycles[k] >> (32'd4 * (32'(CYC_DIGITS) - 32'd1 - w_idx)));
      end
      if ((w_py >= v_base + 32'(HEX_DIGIT_HEIGHT)) &&
          (w_py < v_base + 32'(2 * HEX_DIGIT_HEIGHT)) &&
          (w_idx < 32'(TIME_DIGITS))) begin
        w_digit_req = 1'b1;
        w_digit     = 4'(r_time[k] >> (32'd4 * (32'(TIME_DIGITS) - 32'd1 - w_idx)));
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_digit_req <= 1'b0;
      r_digit     <= 4'd0;
    end else begin
      r_digit_req <= w_digit_req;
      r_digit     <= w_digit;
    end
  end

  // ---------------- outputs ----------------
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign bus.cycles[CYCLE_WIDTH*g +: CYCLE_WIDTH] = r_cycles[g];
    assign bus.time_bcd[TIME_W*g +: TIME_W]         = r_time[g];
    assign bus.running[g]                           = (r_state[g] == ST_RUNNING);
    assign bus.done[g]                              = (r_state[g] == ST_DONE);
  end

  assign bus.saturated     = r_sat;
  assign bus.digit_request = r_digit_req;
  assign bus.digit         = r_digit;

endmodule

// File: tb/tb_perf_counter_multi.sv
// Purpose: self-checking bench for perf_counter_multi (2 channels, 8-bit cycles, 2 BCD digits, tick=4).
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none.
module tb_perf_counter_multi;

  localparam int NCH   = 2;
  localparam int CW    = 8;
  localparam int TD    = 2;
  localparam int TICK  = 4;
  localparam int DW    = 16;
  localparam int DH    = 32;
  localparam int TOPY  = 384;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  perf_counter_multi_if #(.NUM_CHANNELS(NCH), .CYCLE_WIDTH(CW), .TIME_DIGITS(TD)) bus ();

  perf_counter_multi #(
    .NUM_CHANNELS(NCH), .CYCLE_WIDTH(CW), .TIME_DIGITS(TD), .CLKS_PER_TICK(TICK),
    .HEX_DIGIT_WIDTH(DW), .HEX_DIGIT_HEIGHT(DH), .TOP_Y(TOPY)
  ) dut (
    .CLK_50(clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel a mode (0 idle, 1 running, 2 done) and the total number of
  // clock edges spent running. All displayed values derive from that total arithmetically.
  int         m_mode [NCH];
  int         m_run  [NCH];
  logic       m_req;
  logic [3:0] m_dig;

  function automatic logic [7:0] e_cyc(int k);
    return (m_run[k] > 255) ? 8'hFF : 8'(m_run[k]);
  endfunction

  function automatic logic [7:0] e_time(int k);
    int t;
    t = m_run[k] / TICK;
    if (t > 99) t = 99;
    return {4'(t / 10), 4'(t % 10)};
  endfunction

  function automatic logic e_sat(int k);
    return (m_run[k] >= 255) || (m_run[k] / TICK >= 99);
  endfunction

  task automatic ov_calc(input int x, input int y, output logic req, output logic [3:0] dig);
    int line, ch, idx;
    logic [7:0] v;
    req = 1'b0;
    dig = 4'd0;
    if (y >= TOPY) begin
      line = (y - TOPY) / DH;
      ch   = line / 2;
      idx  = x / DW;
      if (ch < NCH && idx < 2) begin
        v   = (line % 2 == 0) ? e_cyc(ch) : e_time(ch);
        req = 1'b1;
        dig = (idx == 0) ? v[7:4] : v[3:0];
      end
    end
  endtask

  // Advances the model through the coming edge using the inputs currently applied.
  task automatic model_edge();
    logic       rq;
    logic [3:0] dg;
    logic       s_hit, p_hit;
    ov_calc(int'(bus.pixel_x), int'(bus.pixel_y), rq, dg);
    m_req = reset ? 1'b0 : rq;
    m_dig = reset ? 4'd0 : dg;
    for (int k = 0; k < NCH; k++) begin
      s_hit = bus.pc_valid && (bus.pc == bus.start_pc[16*k +: 16]);
      p_hit = bus.pc_valid && (bus.pc == bus.stop_pc[16*k +: 16]);
      if (reset || bus.clear) begin
        m_mode[k] = 0;
        m_run[k]  = 0;
      end else begin
        if (m_mode[k] == 1) m_run[k]++;
        if (m_mode[k] == 0 && s_hit) m_mode[k] = 1;
        else if (m_mode[k] == 1 && p_hit) m_mode[k] = 2;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic hit(input logic [15:0] addr);
    bus.pc       = addr;
    bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++; if (bus.cycles !== 16'h0) begin errors++; $display("FAIL reset_cycles got=%h exp=0", bus.cycles); end
    checks++; if (bus.time_bcd !== 16'h0) begin errors++; $display("FAIL reset_time got=%h exp=0", bus.time_bcd); end
    checks++; if (bus.running !== 2'b00 || bus.done !== 2'b00) begin errors++; $display("FAIL reset_state run=%b done=%b exp=00/00", bus.running, bus.done); end
    checks++; if (bus.saturated !== 2'b00) begin errors++; $display("FAIL reset_sat got=%b exp=00", bus.saturated); end
    checks++; if (bus.digit_request !== 1'b0 || bus.digit !== 4'd0) begin errors++; $display("FAIL reset_overlay req=%b dig=%h exp=0/0", bus.digit_request, bus.digit); end
  endtask

  task automatic test_single_window();
    bus.start_pc = {16'hFFFF, 16'h0010};
    bus.stop_pc  = {16'hFFFE, 16'h0020};
    pulse_clear();
    bus.pc = 16'h0010;          // present but not valid: must not start
    repeat (5) step();
    checks++; if (bus.running[0] !== 1'b0) begin errors++; $display("FAIL invalid_pc_start running=%b exp=0", bus.running[0]); end
    hit(16'h0010);
    checks++; if (bus.running[0] !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", bus.running[0]); end
    bus.pc = 16'h0020;          // stop address without valid: ignored
    repeat (19) step();
    hit(16'h0020);
    checks++; if (bus.cycles[7:0] !== 8'd20) begin errors++; $display("FAIL window_cycles got=%0d exp=20", bus.cycles[7:0]); end
    checks++; if (bus.time_bcd[7:0] !== 8'h05) begin errors++; $display("FAIL window_time got=%h exp=05", bus.time_bcd[7:0]); end
    checks++; if (bus.done[0] !== 1'b1 || bus.running[0] !== 1'b0) begin errors++; $display("FAIL window_state done=%b run=%b exp=1/0", bus.done[0], bus.running[0]); end
    hit(16'h0010);              // start match in DONE is ignored
    repeat (99) step();
    checks++; if (bus.cycles[7:0] !== 8'd20 || bus.time_bcd[7:0] !== 8'h05) begin errors++; $display("FAIL window_hold cyc=%0d time=%h exp=20/05", bus.cycles[7:0], bus.time_bcd[7:0]); end
    checks++; if (bus.done[0] !== 1'b1) begin errors++; $display("FAIL window_hold_done got=%b exp=1", bus.done[0]); end
  endtask

  task automatic test_saturation();
    pulse_clear();
    hit(16'h0010);
    repeat (300) step();
    checks++; if (bus.cycles[7:0] !== 8'hFF) begin errors++; $display("FAIL sat_cycles got=%h exp=ff", bus.cycles[7:0]); end
    checks++; if (bus.saturated !== 2'b01) begin errors++; $display("FAIL sat_flag got=%b exp=01", bus.saturated); end
    checks++; if (bus.running[0] !== 1'b1) begin errors++; $display("FAIL sat_running got=%b exp=1", bus.running[0]); end
    checks++; if (bus.time_bcd[7:0] !== 8'h75) begin errors++; $display("FAIL sat_time got=%h exp=75", bus.time_bcd[7:0]); end
  endtask

  task automatic test_same_start_stop();
    pulse_clear();
    bus.start_pc = {16'h0040, 16'h0010};
    bus.stop_pc  = {16'h0040, 16'h0020};
    repeat (3) step();
    hit(16'h0040);
    checks++; if (bus.running[1] !== 1'b1 || bus.done[1] !== 1'b0) begin errors++; $display("FAIL eq_first run=%b done=%b exp=1/0", bus.running[1], bus.done[1]); end
    repeat (6) step();
    hit(16'h0040);
    checks++; if (bus.cycles[15:8] !== 8'd7) begin errors++; $display("FAIL eq_cycles got=%0d exp=7", bus.cycles[15:8]); end
    checks++; if (bus.done[1] !== 1'b1 || bus.time_bcd[15:8] !== 8'h01) begin errors++; $display("FAIL eq_done done=%b time=%h exp=1/01", bus.done[1], bus.time_bcd[15:8]); end
    checks++; if (bus.cycles[7:0] !== 8'd0 || bus.running[0] !== 1'b0 || bus.done[0] !== 1'b0) begin errors++; $display("FAIL eq_ch0_idle cyc=%0d run=%b done=%b exp=0/0/0", bus.cycles[7:0], bus.running[0], bus.done[0]); end
  endtask

  task automatic test_clear_reset_priority();
    pulse_clear();
    bus.clear    = 1'b1;
    bus.pc       = 16'h0010;
    bus.pc_valid = 1'b1;
    step();
    bus.clear    = 1'b0;
    bus.pc_valid = 1'b0;
    step();
    checks++; if (bus.running[0] !== 1'b0 || bus.cycles[7:0] !== 8'd0) begin errors++; $display("FAIL clear_vs_start run=%b cyc=%0d exp=0/0", bus.running[0], bus.cycles[7:0]); end
    hit(16'h0010);
    repeat (5) step();
    checks++; if (bus.running[0] !== 1'b1 || bus.cycles[7:0] !== 8'd5) begin errors++; $display("FAIL restart run=%b cyc=%0d exp=1/5", bus.running[0], bus.cycles[7:0]); end
    bus.pixel_x = 10'd0;
    bus.pixel_y = 10'(TOPY);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.cycles !== 16'h0 || bus.time_bcd !== 16'h0 || bus.running !== 2'b00 || bus.done !== 2'b00 || bus.saturated !== 2'b00) begin
      errors++; $display("FAIL midrun_reset cyc=%h time=%h run=%b done=%b sat=%b exp=all 0", bus.cycles, bus.time_bcd, bus.running, bus.done, bus.saturated);
    end
    checks++; if (bus.digit_request !== 1'b0 || bus.digit !== 4'd0) begin errors++; $display("FAIL midrun_reset_ovl req=%b dig=%h exp=0/0", bus.digit_request, bus.digit); end
    bus.pixel_y = 10'd0;
  endtask

  task automatic test_overlay();
    logic       prev_req, e_req;
    logic [3:0] prev_dig, e_dig;
    bus.start_pc = {16'hFFFF, 16'h0010};
    bus.stop_pc  = {16'hFFFE, 16'h0020};
    pulse_clear();
    hit(16'h0010);
    repeat (164) step();
    hit(16'h0020);              // ch0 frozen at 165 = 0xA5 cycles, 41 ticks
    checks++; if (bus.cycles[7:0] !== 8'hA5) begin errors++; $display("FAIL ovl_freeze got=%h exp=a5", bus.cycles[7:0]); end
    // Cycle line: hex digits A then 5, nothing beyond two cells.
    bus.pixel_y = 10'(TOPY);
    prev_req = 1'b0;
    prev_dig = 4'd0;
    for (int x = 0; x < 64; x++) begin
      bus.pixel_x = 10'(x);
      step();
      e_req = (x < 32);
      e_dig = (x < 16) ? 4'hA : ((x < 32) ? 4'h5 : 4'h0);
      checks++; if (bus.digit_request !== e_req || bus.digit !== e_dig) begin errors++; $display("FAIL ovl_cyc x=%0d req=%b dig=%h exp=%b/%h", x, bus.digit_request, bus.digit, e_req, e_dig); end
      prev_req = e_req;
      prev_dig = e_dig;
      bus.pixel_x = 10'(x + 16);
      #1;
      checks++; if (bus.digit_request !== prev_req || bus.digit !== prev_dig) begin errors++; $display("FAIL ovl_latency x=%0d req=%b dig=%h exp=%b/%h", x, bus.digit_request, bus.digit, prev_req, prev_dig); end
    end
    // Time line: BCD digits of 41 ticks.
    bus.pixel_y = 10'(TOPY + DH);
    for (int x = 0; x < 48; x++) begin
      bus.pixel_x = 10'(x);
      step();
      e_req = (x < 32);
      e_dig = (x < 16) ? 4'h4 : ((x < 32) ? 4'h1 : 4'h0);
      checks++; if (bus.digit_request !== e_req || bus.digit !== e_dig) begin errors++; $display("FAIL ovl_time x=%0d req=%b dig=%h exp=%b/%h", x, bus.digit_request, bus.digit, e_req, e_dig); end
    end
  endtask

  task automatic test_overlay_bounds();
    int rows [2];
    rows[0] = TOPY - 1;
    rows[1] = TOPY + 4 * DH;
    for (int r = 0; r < 2; r++) begin
      bus.pixel_y = 10'(rows[r]);
      for (int x = 0; x < 64; x += 3) begin
        bus.pixel_x = 10'(x);
        step();
        checks++; if (bus.digit_request !== 1'b0 || bus.digit !== 4'd0) begin errors++; $display("FAIL ovl_bounds y=%0d x=%0d req=%b dig=%h exp=0/0", rows[r], x, bus.digit_request, bus.digit); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs [3];
    logic [15:0] ec, et;
    logic [1:0]  er, ed, es;
    addrs[0] = 16'h0010;
    addrs[1] = 16'h0020;
    addrs[2] = 16'h0030;
    pulse_clear();
    for (int n = 0; n < 2000; n++) begin
      if (n % 150 == 0) begin
        for (int k = 0; k < NCH; k++) begin
          bus.start_pc[16*k +: 16] = addrs[$urandom_range(0, 2)];
          bus.stop_pc[16*k +: 16]  = addrs[$urandom_range(0, 2)];
        end
      end
      bus.pc_valid = ($urandom_range(0, 3) == 0);
      bus.pc       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 2)];
      bus.clear    = ($urandom_range(0, 199) == 0);
      reset        = ($urandom_range(0, 699) == 0);
      bus.pixel_x  = 10'($urandom_range(0, 79));
      bus.pixel_y  = 10'($urandom_range(TOPY - 8, TOPY + 4 * DH + 8));
      step();
      for (int k = 0; k < NCH; k++) begin
        ec[8*k +: 8] = e_cyc(k);
        et[8*k +: 8] = e_time(k);
        er[k]        = (m_mode[k] == 1);
        ed[k]        = (m_mode[k] == 2);
        es[k]        = e_sat(k);
      end
      checks++; if (bus.cycles !== ec) begin errors++; $display("FAIL rnd_cycles n=%0d got=%h exp=%h", n, bus.cycles, ec); end
      checks++; if (bus.time_bcd !== et) begin errors++; $display("FAIL rnd_time n=%0d got=%h exp=%h", n, bus.time_bcd, et); end
      checks++; if (bus.running !== er || bus.done !== ed) begin errors++; $display("FAIL rnd_state n=%0d run=%b done=%b exp=%b/%b", n, bus.running, bus.done, er, ed); end
      checks++; if (bus.saturated !== es) begin errors++; $display("FAIL rnd_sat n=%0d got=%b exp=%b", n, bus.saturated, es); end
      checks++; if (bus.digit_request !== m_req || bus.digit !== m_dig) begin errors++; $display("FAIL rnd_overlay n=%0d req=%b dig=%h exp=%b/%h", n, bus.digit_request, bus.digit, m_req, m_dig); end
    end
    bus.clear = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.pc       = 16'h0;
    bus.pc_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.start_pc = '0;
    bus.stop_pc  = '0;
    bus.pixel_x  = 10'd0;
    bus.pixel_y  = 10'd0;
    for (int k = 0; k < NCH; k++) begin
      m_mode[k] = 0;
      m_run[k]  = 0;
    end
    m_req = 1'b0;
    m_dig = 4'd0;

    test_reset();
    test_single_window();
    test_saturation();
    test_same_start_stop();
    test_clear_reset_priority();
    test_overlay();
    test_overlay_bounds();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
